uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
// - Receive buffer directly downstream of the UART receiver; captures each received character
//   (valid/data/break strobe) into a circular FIFO for the CPU/bus side to drain at its own pace.
// - Provides occupancy, sticky overrun/break status and a level-threshold interrupt.
// - Decouples the bit-rate domain from bus read latency; single clock domain (clk).
// PARAMETERS
// - PAYLOAD_BITS    8      character width; must match the receiver payload width
// - DEPTH           16     FIFO entries; power of two, >= 2
// - THRESHOLD       8      irq asserts when count >= THRESHOLD; range 1..DEPTH
// - TIMEOUT_CYCLES  20000  idle cycles before timeout flag (only with UART_RX_FIFO_TIMEOUT_EN)
// PORTS
// - clk        in   1                  system clock
// - resetn     in   1                  reset: synchronous, active-low
// - rx_valid   in   1                  one-cycle strobe: character received
// - rx_data    in   PAYLOAD_BITS       received character, qualified by rx_valid
// - rx_break   in   1                  break indication, qualified by rx_valid
// - rd_en      in   1                  pop request from bus side
// - flush      in   1                  discard all contents
// - clr_flags  in   1                  clear sticky overrun/break_seen
// - rd_data    out  PAYLOAD_BITS       popped character (registered)
// - rd_valid   out  1                  one-cycle strobe: rd_data updated
// - count      out  $clog2(DEPTH)+1    entries held, 0..DEPTH
// - empty      out  1                  count == 0
// - full       out  1                  count == DEPTH
// - overrun    out  1                  sticky: character dropped because FIFO full
// - break_seen out  1                  sticky: break received
// - timeout    out  1                  idle-data timeout flag
// - irq        out  1                  (count >= THRESHOLD) | overrun | timeout
// BEHAVIOUR
// - Reset: pointers/count 0, empty=1, full=0, rd_data=0, rd_valid=0, all flags 0, irq=0.
// - Push: rx_valid & ~rx_break & (~full | pop this cycle) -> store at wr_ptr, wr_ptr++ (wraps mod DEPTH).
// - Break: rx_valid & rx_break -> nothing stored; break_seen <= 1.
// - Overflow: rx_valid & ~rx_break & full & ~pop -> character dropped, overrun <= 1, contents untouched.
// - Pop: rd_en & ~empty -> rd_data <= mem[rd_ptr] next cycle, rd_valid=1 for that cycle, rd_ptr++.
// - rd_en while empty: ignored, rd_valid stays 0, rd_data holds; no write-through bypass
//   (push+rd_en on empty: push only).
// - Push+pop same cycle with count in 1..DEPTH: both happen, count unchanged.
// - count/empty/full/irq are registered state; updated the cycle after push/pop.
// - flush: highest priority; pointers/count <- 0, same-cycle push/pop discarded, rd_valid=0;
//   flags not cleared.
// - clr_flags: clears overrun/break_seen; a setting event in the same cycle wins (flag stays 1).
// - Pointers $clog2(DEPTH) bits; count kept separately, one bit wider; never exceeds DEPTH
//   or underflows.
// - resetn low mid-operation: full reset to reset values next edge; in-flight data lost.
// CONFIGURATION
// - UART_RX_FIFO_TIMEOUT_EN defined: idle counter clears on every push/pop/flush and counts while
//   count != 0; on reaching TIMEOUT_CYCLES sets timeout (saturates). timeout clears on next pop,
//   flush or reset. Lets software drain partial frames below THRESHOLD.
// - Not defined: no counter synthesised; timeout tied 0; irq = (count>=THRESHOLD)|overrun.
// TESTING
// - Reset, then push 0x41,0x42,0x43; 3x rd_en -> rd_data 0x41,0x42,0x43, each with rd_valid; empty=1.
// - Push 16 chars (DEPTH=16) -> full=1, count=16; 17th push -> dropped, overrun=1, irq=1;
//   pops return first 16 in order.
// - Full FIFO, rx_valid and rd_en same cycle -> oldest popped, new char stored, count stays 16,
//   no overrun.
// - rx_valid with rx_break=1, data 0x00 -> count unchanged, break_seen=1; clr_flags -> break_seen=0.
// - Push 8 chars (THRESHOLD=8) -> irq rises after 8th push; one pop -> irq falls;
//   flush -> count=0, empty=1.
// - TIMEOUT_EN, TIMEOUT_CYCLES=100: push 1 char, idle 100 cycles -> timeout=1, irq=1;
//   pop -> timeout=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: buffers characters, tracks sticky overrun/break status, raises a level irq.
// Optional idle-data timeout flag is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int DEPTH          = 16,
  parameter int THRESHOLD      = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       rx_valid,
  input  logic [PAYLOAD_BITS-1:0]    rx_data,
  input  logic                       rx_break,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clr_flags,
  output logic [PAYLOAD_BITS-1:0]    rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overrun,
  output logic                       break_seen,
  output logic                       timeout,
  output logic                       irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [PAYLOAD_BITS-1:0] mem_d [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    empty_q, empty_d;
  logic                    full_q, full_d;
  logic [PAYLOAD_BITS-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    break_seen_q, break_seen_d;
  logic                    irq_q, irq_d;
  logic                    timeout_d;

  logic pop;
  logic push;
  logic ovf;
  logic brk;

  always_comb begin
    pop  = rd_en & ~empty_q;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push = rx_valid & ~rx_break & (~full_q | pop);
    ovf  = rx_valid & ~rx_break & full_q & ~pop & ~flush;
    brk  = rx_valid & rx_break;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = rx_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    overrun_d    = ovf | (overrun_q & ~clr_flags);
    break_seen_d = brk | (break_seen_q & ~clr_flags);

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    irq_d   = (count_d >= CW'(THRESHOLD)) | overrun_d | timeout_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      break_seen_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      overrun_q    <= overrun_d;
      break_seen_q <= break_seen_d;
      irq_q        <= irq_d;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q;

  // Idle time only accumulates while data sits unread; saturates at the limit.
  always_comb begin
    idle_d = idle_q;
    if (flush | push | pop) begin
      idle_d = '0;
    end else if ((count_q != '0) && (idle_q != TW'(TIMEOUT_CYCLES))) begin
      idle_d = idle_q + TW'(1);
    end

    if (flush | pop) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q | (idle_d == TW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_d = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overrun    = overrun_q;
  assign break_seen = break_seen_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int PB    = 8;
  localparam int DEPTH = 16;
  localparam int TH    = 8;
  localparam int TO    = 100;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [PB-1:0] rx_data = '0;
  logic          rx_break = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_flags = 1'b0;
  logic [PB-1:0] rd_data;
  logic          rd_valid;
  logic [$clog2(DEPTH):0] count;
  logic          empty, full, overrun, break_seen, timeout, irq;

  uart_rx_fifo #(
    .PAYLOAD_BITS(PB), .DEPTH(DEPTH), .THRESHOLD(TH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .rd_en(rd_en), .flush(flush), .clr_flags(clr_flags),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
    .full(full), .overrun(overrun), .break_seen(break_seen), .timeout(timeout),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [PB-1:0] mq[$];
  logic [PB-1:0] m_rd_data = '0;
  bit            m_rd_valid = 0;
  bit            m_ovr = 0;
  bit            m_brk = 0;
  bit            m_to = 0;
  int            m_idle = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit rv, input logic [PB-1:0] d, input bit brk,
                              input bit re, input bit fl, input bit cf, input bit rn);
    int sz;
    bit pop, push, ovf;
    sz = mq.size();
    pop = re && (sz > 0);
    push = 0;
    ovf = 0;
    if (!rn) begin
      mq.delete();
      m_rd_data = '0; m_rd_valid = 0; m_ovr = 0; m_brk = 0; m_to = 0; m_idle = 0;
    end else begin
      m_rd_valid = 0;
      if (fl) begin
        mq.delete();
      end else begin
        if (pop) begin
          m_rd_data = mq.pop_front();
          m_rd_valid = 1;
        end
        if (rv && !brk) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(d);
            push = 1;
          end else begin
            ovf = 1;
          end
        end
      end
      m_ovr = ovf | (m_ovr & !cf);
      m_brk = (rv && brk) | (m_brk & !cf);
`ifdef UART_RX_FIFO_TIMEOUT_EN
      if (fl || push || pop) m_idle = 0;
      else if (sz != 0 && m_idle < TO) m_idle++;
      if (fl || pop) m_to = 0;
      else if (m_idle == TO) m_to = 1;
`endif
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("break_seen", 32'(break_seen), 32'(m_brk));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("irq", 32'(irq), 32'((sz >= TH) || m_ovr || m_to));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    chk("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  task automatic step(input bit rv, input logic [PB-1:0] d, input bit brk, input bit re,
                      input bit fl, input bit cf, input bit rn);
    rx_valid = rv; rx_data = d; rx_break = brk; rd_en = re;
    flush = fl; clr_flags = cf; resetn = rn;
    @(posedge clk);
    model_update(rv, d, brk, re, fl, cf, rn);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic push_c(input logic [PB-1:0] d); step(1, d, 0, 0, 0, 0, 1); endtask
  task automatic pop_c();  step(0, '0, 0, 1, 0, 0, 1); endtask
  task automatic idle_c(); step(0, '0, 0, 0, 0, 0, 1); endtask
  task automatic flush_c(); step(0, '0, 0, 0, 1, 0, 1); endtask
  task automatic clr_c();  step(0, '0, 0, 0, 0, 1, 1); endtask

  initial begin
    logic [PB-1:0] abc [3];
    abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;

    repeat (3) step(0, '0, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // ordered push/pop of three characters
    for (int i = 0; i < 3; i++) push_c(abc[i]);
    for (int i = 0; i < 3; i++) begin
      pop_c();
      chk("abc_data", 32'(rd_data), 32'(abc[i]));
      chk("abc_valid", 32'(rd_valid), 32'd1);
    end
    chk("abc_empty", 32'(empty), 32'd1);
    pop_c();
    chk("empty_pop_valid", 32'(rd_valid), 32'd0);
    chk("empty_pop_hold", 32'(rd_data), 32'h43);

    // fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push_c(PB'(i + 1));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    push_c(8'hEE);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    chk("ovf_irq", 32'(irq), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      pop_c();
      chk("drain_data", 32'(rd_data), 32'(i + 1));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    clr_c();
    chk("clr_overrun", 32'(overrun), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_c(PB'(8'h10 + i));
    step(1, 8'h99, 0, 1, 0, 0, 1);
    chk("fullpp_data", 32'(rd_data), 32'h10);
    chk("fullpp_count", 32'(count), 32'(DEPTH));
    chk("fullpp_ovr", 32'(overrun), 32'd0);
    flush_c();
    chk("flush_count", 32'(count), 32'd0);

    // push and rd_en on empty: push only
    step(1, 8'h5A, 0, 1, 0, 0, 1);
    chk("empty_pp_valid", 32'(rd_valid), 32'd0);
    chk("empty_pp_count", 32'(count), 32'd1);
    flush_c();

    // break handling; setting event beats clear in the same cycle
    step(1, 8'h00, 1, 0, 0, 0, 1);
    chk("brk_count", 32'(count), 32'd0);
    chk("brk_seen", 32'(break_seen), 32'd1);
    step(1, 8'h00, 1, 0, 0, 1, 1);
    chk("brk_clr_race", 32'(break_seen), 32'd1);
    clr_c();
    chk("brk_clr", 32'(break_seen), 32'd0);

    // threshold
    for (int i = 0; i < TH - 1; i++) push_c(PB'(8'h60 + i));
    chk("th_below_irq", 32'(irq), 32'd0);
    push_c(8'h6F);
    chk("th_irq", 32'(irq), 32'd1);
    pop_c();
    chk("th_pop_irq", 32'(irq), 32'd0);
    flush_c();
    chk("th_flush_count", 32'(count), 32'd0);
    chk("th_flush_empty", 32'(empty), 32'd1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    push_c(8'h77);
    repeat (TO - 1) idle_c();
    chk("to_before", 32'(timeout), 32'd0);
    idle_c();
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_irq", 32'(irq), 32'd1);
    pop_c();
    chk("to_pop_clear", 32'(timeout), 32'd0);
`else
    push_c(8'h77);
    repeat (TO + 5) idle_c();
    chk("to_disabled", 32'(timeout), 32'd0);
    pop_c();
`endif

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 3000; n++) begin
      bit rv, brk, re, fl, cf;
      int phase;
      phase = (n / 200) % 2;
      rv  = ($urandom_range(99) < (phase == 0 ? 70 : 30));
      re  = ($urandom_range(99) < (phase == 0 ? 30 : 70));
      brk = ($urandom_range(15) == 0);
      fl  = ($urandom_range(63) == 0);
      cf  = ($urandom_range(31) == 0);
      step(rv, PB'($urandom), brk, re, fl, cf, 1);
    end

    // reset mid-operation
    for (int i = 0; i < 5; i++) push_c(PB'(8'hA0 + i));
    step(1, 8'hFF, 1, 1, 0, 0, 0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_data", 32'(rd_data), 32'd0);
    idle_c();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
